// File: rtl/udma_uart_poll_pkg.sv
// Shared definitions for the UART RX polling sequencer.
// Optional feature macro: UDMA_UART_POLL_ERR_EN (adds the ERROR register poll
// state and the sticky parity/overflow flags).
package udma_uart_poll_pkg;

    localparam logic [4:0] UART_REG_VALID = 5'h0C;
    localparam logic [4:0] UART_REG_DATA  = 5'h0D;
    localparam logic [4:0] UART_REG_ERROR = 5'h0A;

`ifdef UDMA_UART_POLL_ERR_EN
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_RD_VALID = 3'd2,
        ST_RD_DATA  = 3'd3,
        ST_RD_ERR   = 3'd4
    } poll_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_RD_VALID = 2'd2,
        ST_RD_DATA  = 2'd3
    } poll_state_e;
`endif

    // States in which the sequencer owns an outstanding register read.
    function automatic logic is_read_state(input poll_state_e st);
        logic rd;
        case (st)
            ST_RD_VALID: rd = 1'b1;
            ST_RD_DATA:  rd = 1'b1;
`ifdef UDMA_UART_POLL_ERR_EN
            ST_RD_ERR:   rd = 1'b1;
`endif
            default:     rd = 1'b0;
        endcase
        return rd;
    endfunction

    // Register address presented by the sequencer in a given state.
    function automatic logic [4:0] poll_addr(input poll_state_e st);
        logic [4:0] a;
        case (st)
            ST_RD_VALID: a = UART_REG_VALID;
            ST_RD_DATA:  a = UART_REG_DATA;
`ifdef UDMA_UART_POLL_ERR_EN
            ST_RD_ERR:   a = UART_REG_ERROR;
`endif
            default:     a = 5'h00;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/udma_uart_poll_fifo.sv
// Small synchronous byte FIFO holding bytes fetched by the RX poller.
// Pop on empty is ignored; push on full is ignored unless a pop frees a slot
// in the same cycle.
module udma_uart_poll_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    output logic [7:0]               data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push_s, do_pop_s;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW + 1)'(DEPTH));
    assign count_o   = count_q;
    assign data_o    = mem_q[rptr_q];
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Next-state pointers and occupancy from the qualified push/pop pair.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push_s) begin
            wptr_d = wptr_q + AW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (do_pop_s) begin
            rptr_d = rptr_q + AW'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/udma_uart_rx_poller.sv
// UART RX poller: shares the UART register cfg port between the host and an
// internal sequencer that reads VALID then DATA during host-idle cycles and
// queues received bytes in a FIFO. Host always wins the port.
// Optional feature macro: UDMA_UART_POLL_ERR_EN (ERROR register poll after
// each byte, sticky err_parity_o / err_overflow_o, err_clr_i).
module udma_uart_rx_poller
    import udma_uart_poll_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [31:0]                   host_cfg_data_i,
    input  logic [4:0]                    host_cfg_addr_i,
    input  logic                          host_cfg_valid_i,
    input  logic                          host_cfg_rwn_i,
    output logic [31:0]                   host_cfg_data_o,
    output logic                          host_cfg_ready_o,
    output logic [31:0]                   cfg_data_o,
    output logic [4:0]                    cfg_addr_o,
    output logic                          cfg_valid_o,
    output logic                          cfg_rwn_o,
    input  logic [31:0]                   cfg_data_i,
    input  logic                          cfg_ready_i,
    input  logic                          poll_en_i,
    input  logic [CNT_W-1:0]              poll_interval_i,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
`ifdef UDMA_UART_POLL_ERR_EN
    input  logic                          err_clr_i,
    output logic                          err_parity_o,
    output logic                          err_overflow_o,
`endif
    output logic                          poll_busy_o
);

    poll_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             poll_req_s;
    logic             poll_done_s;
    logic             push_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
`ifdef UDMA_UART_POLL_ERR_EN
    logic [1:0]       err_q, err_d;
    logic [1:0]       err_set_s;
`endif

    assign poll_req_s  = is_read_state(state_q);
    // A poller read retires only when the host is absent and the UART is ready.
    assign poll_done_s = poll_req_s && !host_cfg_valid_i && cfg_ready_i;
    assign poll_busy_o = (state_q != ST_IDLE);
    assign rx_valid_o  = !fifo_empty_s;

    // Combinational cfg port mux: host has absolute priority.
    always_comb begin
        cfg_valid_o      = 1'b0;
        cfg_addr_o       = 5'h00;
        cfg_rwn_o        = 1'b0;
        cfg_data_o       = 32'h0000_0000;
        host_cfg_data_o  = 32'h0000_0000;
        host_cfg_ready_o = 1'b0;
        if (host_cfg_valid_i) begin
            cfg_valid_o      = 1'b1;
            cfg_addr_o       = host_cfg_addr_i;
            cfg_rwn_o        = host_cfg_rwn_i;
            cfg_data_o       = host_cfg_data_i;
            host_cfg_data_o  = cfg_data_i;
            host_cfg_ready_o = cfg_ready_i;
        end else begin
            cfg_valid_o = poll_req_s;
            cfg_addr_o  = poll_addr(state_q);
            cfg_rwn_o   = poll_req_s;
        end
    end

    // Sequencer next-state, interval counter and FIFO push decision.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push_s  = 1'b0;
`ifdef UDMA_UART_POLL_ERR_EN
        err_set_s = 2'b00;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (poll_en_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!poll_en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if ((cnt_q >= poll_interval_i) && !fifo_full_s) begin
                    state_d = ST_RD_VALID;
                    cnt_d   = '0;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RD_VALID: begin
                if (!poll_en_i) begin
                    state_d = ST_IDLE;
                end else if (poll_done_s) begin
                    state_d = cfg_data_i[0] ? ST_RD_DATA : ST_WAIT;
                end else begin
                    state_d = ST_RD_VALID;
                end
            end
            ST_RD_DATA: begin
                // A completing read always delivers its byte, even if polling
                // is being switched off in the same cycle.
                push_s = poll_done_s;
                if (!poll_en_i) begin
                    state_d = ST_IDLE;
                end else if (host_cfg_valid_i) begin
                    // Host may have consumed DATA itself: re-check VALID.
                    state_d = ST_RD_VALID;
                end else if (poll_done_s) begin
`ifdef UDMA_UART_POLL_ERR_EN
                    state_d = ST_RD_ERR;
`else
                    state_d = ST_WAIT;
`endif
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
`ifdef UDMA_UART_POLL_ERR_EN
            ST_RD_ERR: begin
                if (poll_done_s) begin
                    err_set_s = cfg_data_i[1:0];
                end else begin
                    err_set_s = 2'b00;
                end
                if (!poll_en_i) begin
                    state_d = ST_IDLE;
                end else if (poll_done_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_RD_ERR;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state and interval counter registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef UDMA_UART_POLL_ERR_EN
    // Sticky error flags: a set in the same cycle overrides the clear.
    always_comb begin
        err_d = (err_q & ~{2{err_clr_i}}) | err_set_s;
    end

    // Error flag registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_q <= 2'b00;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_parity_o   = err_q[1];
    assign err_overflow_o = err_q[0];
`endif

    udma_uart_poll_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push_s),
        .data_i  (cfg_data_i[7:0]),
        .pop_i   (rx_ready_i),
        .data_o  (rx_data_o),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_o)
    );

endmodule

// File: doc/udma_uart_rx_poller.md
Name: udma_uart_rx_poller

Overview:
- Sits between the host configuration bus and the UART register interface's 5-bit cfg port.
- Arbitrates that port between the host and an internal RX polling sequencer. The sequencer reads VALID (addr 5'h0C) and then DATA (addr 5'h0D), and stores received bytes in a small FIFO.
- Lets software or the event unit drain UART bytes without issuing per-byte register reads.
- Host always has priority. The poller uses only idle cycles.

Parameters:
- FIFO_DEPTH, 8, RX byte FIFO depth. Power of two, ≥2.
- CNT_W, 16, width of the poll interval counter.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  async active-low reset
- host_cfg_data_i  in  32  host write data
- host_cfg_addr_i  in  5  host register address
- host_cfg_valid_i  in  1  host request
- host_cfg_rwn_i  in  1  1=read, 0=write
- host_cfg_data_o  out  32  host read data
- host_cfg_ready_o  out  1  host request accepted
- cfg_data_o  out  32  write data to UART reg if
- cfg_addr_o  out  5  address to UART reg if
- cfg_valid_o  out  1  request to UART reg if
- cfg_rwn_o  out  1  read/write to UART reg if
- cfg_data_i  in  32  read data from UART reg if (combinational, same cycle)
- cfg_ready_i  in  1  UART reg if ready
- poll_en_i  in  1  enable polling sequencer
- poll_interval_i  in  CNT_W  idle cycles between VALID polls
- rx_data_o  out  8  FIFO head byte
- rx_valid_o  out  1  FIFO not empty
- rx_ready_i  in  1  pop FIFO head
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- poll_busy_o  out  1  FSM not in IDLE

Behaviour:

Arbitration and cfg mux:
- The mux is purely combinational.
- If host_cfg_valid_i=1, the host drives all cfg_* outputs. Then host_cfg_data_o=cfg_data_i and host_cfg_ready_o=cfg_ready_i.
- Otherwise the poller drives the cfg_* outputs. The poller only issues reads: cfg_rwn_o=1, cfg_data_o=0.
- host_cfg_data_o=0 when the host is not valid.
- A poller transfer completes only in a cycle with poller grant and cfg_ready_i=1. Read data is sampled from cfg_data_i in that same cycle.

FSM states:
- IDLE: entered on reset, or whenever poll_en_i=0. Counter is cleared. Go to WAIT when poll_en_i=1.
- WAIT:
  - Counter increments each cycle.
  - When counter ≥ poll_interval_i and the FIFO is not full, clear the counter and go to RD_VALID.
  - poll_interval_i=0 means poll on the next cycle.
  - While the FIFO is full, hold in WAIT and saturate the counter. No byte is ever lost.
- RD_VALID: issue a read of 5'h0C.
  - On completion with bit0=1, go to RD_DATA.
  - On completion with bit0=0, go to WAIT.
  - If the host is valid, stall here.
- RD_DATA: issue a read of 5'h0D.
  - This read clears VALID on the UART side.
  - On completion, push cfg_data_i[7:0] and go to WAIT.
  - If the host preempts in this state, go back to RD_VALID instead of stalling. The host may itself have read DATA, so a stale byte must never be pushed.

FIFO:
- Push and pop in the same cycle are allowed when the FIFO is not empty; occupancy is unchanged.
- A pop when empty is ignored.
- The FIFO is full-safe by construction, because the poller never enters RD_VALID while full.

Other rules:
- poll_en_i deasserting in any state sends the FSM to IDLE next cycle. An in-flight cycle that completes in that same cycle still pushes its byte.
- Reset values: all cfg_* outputs 0 when not granted, FIFO empty, rx_valid_o=0, fifo_count_o=0, poll_busy_o=0, state IDLE, counter 0.
- A reset mid-operation discards FIFO contents.
- Latency: a byte present at UART VALID appears on rx_valid_o 2 cycles after leaving WAIT, provided there is no host contention.

Optional Feature:
- Macro: UDMA_UART_POLL_ERR_EN.
- When defined:
  - Adds state RD_ERR after RD_DATA, which reads 5'h0A. Reading it clears the error bits on the UART side.
  - Adds ports err_parity_o and err_overflow_o (1-bit each). These are sticky ORs of read bits [1] and [0].
  - Adds input err_clr_i, which clears both flags. A set in the same cycle wins over the clear.
  - Host preemption in RD_ERR stalls.
- When undefined: RD_DATA returns directly to WAIT, and the ports are absent.

Decomposition:
- Package udma_uart_poll_pkg holds:
  - register address constants VALID=5'h0C, DATA=5'h0D, ERROR=5'h0A;
  - the FSM state enum (2 bits, 3 bits with the error feature).
- Sub-module udma_uart_poll_fifo: a synchronous FIFO with parameter DEPTH, width 8, and ports push/pop/full/empty/count.

Test Plan:
- Reset mid-RD_DATA, then reset released → FIFO empty, rx_valid_o=0, state IDLE; first poll occurs only after poll_en_i=1.
- poll_interval_i=4, model VALID=1 with DATA=8'hA5 → 5 WAIT cycles, reads of 0x0C then 0x0D, rx_data_o=8'hA5, fifo_count_o=1.
- Host read of 0x0D asserted in the cycle the poller would issue DATA → host gets the byte; poller re-reads 0x0C, sees 0, pushes nothing; fifo_count_o unchanged.
- Model streams 10 bytes with FIFO_DEPTH=8 and rx_ready_i=0 → count saturates at 8 with no poll reads while full; after 2 pops, the remaining 2 bytes arrive in order.
- poll_interval_i=0 with VALID=0 → 0x0C read on every other cycle (RD_VALID→WAIT→RD_VALID); host writes interleave with zero stall on host_cfg_ready_o.
- With UDMA_UART_POLL_ERR_EN defined, ERROR read returns 2'b10 → err_parity_o=1 and stays 1; err_clr_i pulse clears it to 0.
